// File: rtl/hdx_link_ctrl_pkg.sv
// ============================================================================
// Module : hdx_link_ctrl_pkg
// Brief  : State encoding and frame line levels for the half-duplex link.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hdx_link_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TX_START = 4'd1,
        TX_DATA  = 4'd2,
        TX_STOP  = 4'd3,
        TURN     = 4'd4,
        RX_WAIT  = 4'd5,
        RX_START = 4'd6,
        RX_DATA  = 4'd7,
        RX_STOP  = 4'd8
    } state_t;

    localparam logic c_start_lvl = 1'b0;
    localparam logic c_stop_lvl  = 1'b1;
    localparam logic c_idle_lvl  = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hdx_bit_timer.sv
// ============================================================================
// Module : hdx_bit_timer
// Brief  : Loadable down-counter; tick marks the last cycle of a loaded span.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hdx_bit_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick
);

    logic [WIDTH-1:0] r_cnt;

    // Loading N yields a tick on the Nth cycle after the load edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign tick = (r_cnt == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/hdx_link_ctrl.sv
// ============================================================================
// Module : hdx_link_ctrl
// Brief  : Half-duplex single-wire link: send a request, optionally receive.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hdx_link_ctrl #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int DATA_W         = 8,
    parameter int TURN_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              expect_rx,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_err,
    output logic              rx_timeout,
    output logic              busy,
    output logic              pad_en,
    output logic              pad_out,
    input  logic              pad_in
);

    import hdx_link_ctrl_pkg::*;

    localparam int c_tw  = $clog2(max_int(CLKS_PER_BIT, TURN_CYCLES)) + 1;
    localparam int c_bw  = $clog2(DATA_W);
    localparam int c_tow = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_tw-1:0]  c_full    = c_tw'(CLKS_PER_BIT);
    localparam logic [c_tw-1:0]  c_half    = c_tw'(CLKS_PER_BIT / 2);
    localparam logic [c_tw-1:0]  c_turn    = c_tw'(TURN_CYCLES);
    localparam logic [c_bw-1:0]  c_last    = c_bw'(DATA_W - 1);
    localparam logic [c_tow-1:0] c_to_last = c_tow'(TIMEOUT_CYCLES - 1);

    state_t              r_state, w_next;
    logic                r_sync1, r_sync2, w_rx;
    logic                r_tx_ready, r_pad_en, r_pad_out, r_expect;
    logic                r_rx_valid, r_rx_err, r_rx_timeout;
    logic [DATA_W-1:0]   r_tx_sh, w_tx_sh_nxt, r_rx_sh, r_rx_data;
    logic [c_bw-1:0]     r_bit_idx;
    logic [c_tow-1:0]    r_to_cnt;
    logic                w_load, w_tick;
    logic [c_tw-1:0]     w_load_val;
    logic                w_accept, w_bit_clr, w_bit_inc, w_rx_shift;
    logic                w_to_clr, w_to_inc, w_timeout, w_rx_done;
    logic                w_pad_en_nxt, w_pad_out_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= c_idle_lvl;
            r_sync2 <= c_idle_lvl;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;

    hdx_bit_timer #(.WIDTH(c_tw)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_val  = c_full;
        w_tx_sh_nxt = r_tx_sh;
        w_accept    = 1'b0;
        w_bit_clr   = 1'b0;
        w_bit_inc   = 1'b0;
        w_rx_shift  = 1'b0;
        w_to_clr    = 1'b0;
        w_to_inc    = 1'b0;
        w_timeout   = 1'b0;
        w_rx_done   = 1'b0;
        case (r_state)
            IDLE: if (tx_valid && r_tx_ready) begin
                w_next      = TX_START;
                w_load      = 1'b1;
                w_accept    = 1'b1;
                w_tx_sh_nxt = tx_data;
            end
            TX_START: if (w_tick) begin
                w_next    = TX_DATA;
                w_load    = 1'b1;
                w_bit_clr = 1'b1;
            end
            TX_DATA: if (w_tick) begin
                w_load = 1'b1;
                if (r_bit_idx == c_last) begin
                    w_next = TX_STOP;
                end else begin
                    w_bit_inc   = 1'b1;
                    w_tx_sh_nxt = r_tx_sh >> 1;
                end
            end
            TX_STOP: if (w_tick) begin
                if (r_expect) begin
                    w_next     = TURN;
                    w_load     = 1'b1;
                    w_load_val = c_turn;
                end else begin
                    w_next = IDLE;
                end
            end
            TURN: if (w_tick) begin
                w_next   = RX_WAIT;
                w_to_clr = 1'b1;
            end
            RX_WAIT: begin
                if (w_rx == c_start_lvl) begin
                    w_next     = RX_START;
                    w_load     = 1'b1;
                    w_load_val = c_half;
                end else if (r_to_cnt == c_to_last) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            // A start bit that is gone at mid-bit was a glitch; keep waiting
            // without restarting the response deadline.
            RX_START: if (w_tick) begin
                if (w_rx == c_start_lvl) begin
                    w_next    = RX_DATA;
                    w_load    = 1'b1;
                    w_bit_clr = 1'b1;
                end else begin
                    w_next = RX_WAIT;
                end
            end
            RX_DATA: if (w_tick) begin
                w_load     = 1'b1;
                w_rx_shift = 1'b1;
                if (r_bit_idx == c_last) w_next = RX_STOP;
                else                     w_bit_inc = 1'b1;
            end
            RX_STOP: if (w_tick) begin
                w_next    = IDLE;
                w_rx_done = 1'b1;
            end
            default: w_next = IDLE;
        endcase

        // Pad controls are registered from the next state so the wire never glitches.
        w_pad_en_nxt  = (w_next == TX_START) || (w_next == TX_DATA) || (w_next == TX_STOP);
        w_pad_out_nxt = c_idle_lvl;
        if (w_next == TX_START)     w_pad_out_nxt = c_start_lvl;
        else if (w_next == TX_DATA) w_pad_out_nxt = w_tx_sh_nxt[0];
        else if (w_next == TX_STOP) w_pad_out_nxt = c_stop_lvl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_ready   <= 1'b0;
            r_pad_en     <= 1'b0;
            r_pad_out    <= c_idle_lvl;
            r_tx_sh      <= '0;
            r_expect     <= 1'b0;
            r_bit_idx    <= '0;
            r_rx_sh      <= '0;
            r_to_cnt     <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_err     <= 1'b0;
            r_rx_timeout <= 1'b0;
        end else begin
            r_tx_ready   <= (w_next == IDLE);
            r_pad_en     <= w_pad_en_nxt;
            r_pad_out    <= w_pad_out_nxt;
            r_tx_sh      <= w_tx_sh_nxt;
            r_rx_valid   <= w_rx_done;
            r_rx_timeout <= w_timeout;
            if (w_accept) r_expect <= expect_rx;
            if (w_bit_clr)      r_bit_idx <= '0;
            else if (w_bit_inc) r_bit_idx <= r_bit_idx + c_bw'(1);
            if (w_rx_shift) r_rx_sh <= {w_rx, r_rx_sh[DATA_W-1:1]};
            if (w_to_clr)      r_to_cnt <= '0;
            else if (w_to_inc) r_to_cnt <= r_to_cnt + c_tow'(1);
            if (w_rx_done) begin
                r_rx_data <= r_rx_sh;
                r_rx_err  <= (w_rx != c_stop_lvl);
            end
        end
    end

    assign tx_ready   = r_tx_ready;
    assign pad_en     = r_pad_en;
    assign pad_out    = r_pad_out;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign rx_err     = r_rx_err;
    assign rx_timeout = r_rx_timeout;
    assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hdx_link_ctrl.sv
// ============================================================================
// Module : tb_hdx_link_ctrl
// Brief  : Randomized bench for hdx_link_ctrl with a behavioural far end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hdx_link_ctrl;

    localparam int CLKS      = 4;
    localparam int DW        = 8;
    localparam int TURN      = 2;
    localparam int TMO       = 64;
    localparam int FRAME_CYC = (DW + 2) * CLKS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          expect_rx = 1'b0;
    logic          tx_ready, rx_valid, rx_err, rx_timeout, busy, pad_en, pad_out;
    logic [DW-1:0] rx_data;
    logic          far_en = 1'b0;
    logic          far_out = 1'b1;
    logic          w_line;

    // Shared wire: whichever end enables its buffer drives it; pulled up when idle.
    assign w_line = pad_en ? pad_out : (far_en ? far_out : 1'b1);

    hdx_link_ctrl #(
        .CLKS_PER_BIT   (CLKS),
        .DATA_W         (DW),
        .TURN_CYCLES    (TURN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .expect_rx  (expect_rx),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .rx_timeout (rx_timeout),
        .busy       (busy),
        .pad_en     (pad_en),
        .pad_out    (pad_out),
        .pad_in     (w_line)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] last_rx = '0;
    int            far_wave[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Far-end line levels per cycle after release: 0/1 driven, 2 released.
    task automatic build_far(input int delay, input bit glitch, input logic [DW-1:0] rd,
                             input bit bad_stop);
        far_wave.delete();
        repeat (delay) far_wave.push_back(2);
        if (glitch) begin
            far_wave.push_back(0);
            repeat (6) far_wave.push_back(2);
        end
        repeat (CLKS) far_wave.push_back(0);
        for (int i = 0; i < DW; i++) repeat (CLKS) far_wave.push_back(int'(rd[i]));
        repeat (CLKS) far_wave.push_back(bad_stop ? 0 : 1);
        far_wave.push_back(2);
    endtask

    task automatic run_txn(input logic [DW-1:0] d, input bit exp_rx, input bit respond,
                           input logic [DW-1:0] rd, input bit bad_stop, input int delay,
                           input bit glitch);
        logic [FRAME_CYC-1:0] obs_wave, exp_wave;
        logic [DW-1:0]        got_data = '0;
        logic                 got_err = 1'b0;
        logic                 prev_en = 1'b0;
        logic                 ready_at_rel = 1'b0;
        int en_cnt = 0, n_val = 0, n_to = 0, contend = 0;
        int rel = -1, to_cyc = -1, cyc = 0, post = 0, widx = 0;
        bit done = 1'b0;

        if (respond) build_far(delay, glitch, rd, bad_stop);
        else         far_wave.delete();
        obs_wave = '0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            int b = i / CLKS;
            exp_wave[i] = (b == 0) ? 1'b0 : (b == DW + 1) ? 1'b1 : d[b-1];
        end

        @(negedge clk);
        check("idle_ready", tx_ready, 1);
        tx_valid  = 1'b1;
        tx_data   = d;
        expect_rx = exp_rx;
        @(negedge clk);
        tx_valid  = 1'b0;
        tx_data   = DW'($urandom);
        expect_rx = 1'($urandom);
        check("ready_drop", {tx_ready, busy}, 2'b01);

        while (!done && cyc < 600) begin
            if (pad_en) begin
                if (en_cnt < FRAME_CYC) obs_wave[en_cnt] = pad_out;
                en_cnt++;
            end
            if (prev_en && !pad_en && rel < 0) begin
                rel          = cyc;
                ready_at_rel = tx_ready;
            end
            if (pad_en && far_en) contend++;
            if (rx_valid) begin
                n_val++;
                got_data = rx_data;
                got_err  = rx_err;
            end
            if (rx_timeout) begin
                n_to++;
                to_cyc = cyc;
            end
            prev_en = pad_en;
            if (rel >= 0) begin
                widx = cyc - rel;
                if (widx < far_wave.size()) begin
                    far_en  = (far_wave[widx] != 2);
                    far_out = (far_wave[widx] != 0);
                end else begin
                    far_en  = 1'b0;
                    far_out = 1'b1;
                    if (tx_ready) post++;
                end
            end
            if (post >= 4) done = 1'b1;
            @(negedge clk);
            cyc++;
        end

        check("txn_budget", done, 1);
        check("pad_en_cycles", en_cnt, FRAME_CYC);
        check("tx_wave", obs_wave, exp_wave);
        check("contention", contend, 0);
        if (!exp_rx) begin
            check("ready_at_release", ready_at_rel, 1);
            check("no_rx_valid", n_val, 0);
            check("no_timeout", n_to, 0);
        end else if (respond) begin
            check("rx_valid_count", n_val, 1);
            check("rx_no_timeout", n_to, 0);
            check("rx_data", got_data, rd);
            check("rx_err", got_err, bad_stop);
            last_rx = rd;
        end else begin
            check("timeout_count", n_to, 1);
            check("timeout_no_valid", n_val, 0);
            check("timeout_latency", to_cyc - rel, TURN + TMO);
        end
        check("rx_data_hold", rx_data, last_rx);
        check("end_idle", {tx_ready, busy}, 2'b10);
    endtask

    initial begin
        int stray;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {pad_en, pad_out, tx_ready, busy, rx_valid, rx_err, rx_timeout},
                  7'b0100000);
            check("reset_rx_data", rx_data, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1);

        run_txn(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        run_txn(8'h11, 1'b1, 1'b1, 8'h3C, 1'b0, 5, 1'b0);
        run_txn(DW'($urandom), 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        run_txn(DW'($urandom), 1'b1, 1'b1, 8'hFF, 1'b1, 4, 1'b0);
        run_txn(DW'($urandom), 1'b1, 1'b1, 8'h96, 1'b0, 3, 1'b1);

        // Abort a request during data bit 3.
        @(negedge clk);
        tx_valid  = 1'b1;
        tx_data   = 8'hC3;
        expect_rx = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (CLKS * 4 + 1) @(negedge clk);
        check("mid_tx_driving", pad_en, 1);
        #2 rst = 1'b1;
        #1 check("reset_async_pad_en", {pad_en, busy}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rx = '0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (rx_valid || rx_timeout || pad_en) stray++;
        end
        check("no_stray_after_reset", stray, 0);
        run_txn(8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            int m;
            m = $urandom_range(0, 2);
            run_txn(DW'($urandom), m != 0, m == 1, DW'($urandom), $urandom_range(0, 3) == 0,
                    $urandom_range(2, 20), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

`default_nettype wire
